// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues in-order imem requests under a credit
// limit, buffers responses in a prefetch queue and presents them to decode.
module fetch_queue #(
  parameter int unsigned        DWIDTH         = 32,
  parameter int unsigned        AWIDTH         = 32,
  parameter logic [31:0]        IMEM_BASE_ADDR = 32'h0100_0000,
  parameter logic [AWIDTH-1:0]  RESET_PC       = AWIDTH'(IMEM_BASE_ADDR),
  parameter int unsigned        DEPTH          = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcsel_i,
  input  logic [AWIDTH-1:0] pc_branch_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] INSN_BYTES = AWIDTH'(4);

  logic [AWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [AWIDTH-1:0] head_pc_q, head_pc_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [AWIDTH-1:0] target;
  logic              credit_ok;
  logic              req_fire;
  logic              rsp_take;
  logic              push;
  logic              pop;
  logic              unused_bits;

  assign target      = {pc_branch_i[AWIDTH-1:2], 2'b00};
  assign unused_bits = &{1'b0, pc_branch_i[1:0]};

  // inflight includes responses already marked for dropping, so the credit
  // check covers every slot a returning response could possibly occupy.
  assign credit_ok        = ({1'b0, count_q} + {1'b0, inflight_q}) < CREDITS;
  assign imem_req_valid_o = !pcsel_i && credit_ok;
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign rsp_take = imem_rsp_valid_i && (inflight_q != '0);
  assign push     = rsp_take && (drop_q == '0) && !pcsel_i;

  assign insn_valid_o = (count_q != '0) && !pcsel_i;
  assign pop          = insn_valid_o && insn_ready_i;
  assign insn_o       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign pc_o         = head_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_take);

    if (pcsel_i) begin
      fetch_pc_d = target;
      head_pc_d  = target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // Every response still outstanding belongs to the abandoned path; drop
      // counts are a subset of inflight, so back-to-back redirects cannot
      // over-count.
      drop_d     = inflight_q - CW'(rsp_take);
    end else begin
      if (req_fire)
        fetch_pc_d = fetch_pc_q + INSN_BYTES;
      if (rsp_take) begin
        if (drop_q != '0)
          drop_d = drop_q - CW'(1);
        else
          wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PW'(1);
        head_pc_d = head_pc_q + INSN_BYTES;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // Queue storage needs no reset: count gates what is ever presented.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= imem_rsp_data_i;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a fixed-latency (1..3 cycle) memory
// whose response word is the request address XOR a key.
module tb_fetch_queue;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] KEY  = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst, pcsel, req_ready, insn_ready;
  logic [31:0] pc_branch;
  logic        req_valid, rsp_valid, insn_valid;
  logic [31:0] req_addr, rsp_data, pc, insn;

  int checks = 0;
  int failures = 0;
  int lat = 1;

  logic        pv1, pv2, pv3;
  logic [31:0] pd1, pd2, pd3;

  always #5 clk = ~clk;

  fetch_queue #(.DWIDTH(32), .AWIDTH(32), .RESET_PC(BASE), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pcsel_i(pcsel), .pc_branch_i(pc_branch),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready),
    .imem_req_addr_o(req_addr), .imem_rsp_valid_i(rsp_valid),
    .imem_rsp_data_i(rsp_data), .insn_valid_o(insn_valid),
    .insn_ready_i(insn_ready), .pc_o(pc), .insn_o(insn)
  );

  // Memory squashes everything outstanding when reset is asserted.
  always @(posedge clk) begin
    if (rst) begin
      pv1 <= 1'b0; pv2 <= 1'b0; pv3 <= 1'b0;
      pd1 <= '0;   pd2 <= '0;   pd3 <= '0;
    end else begin
      pv1 <= req_valid && req_ready; pd1 <= req_addr ^ KEY;
      pv2 <= pv1; pd2 <= pd1;
      pv3 <= pv2; pd3 <= pd2;
    end
  end
  assign rsp_valid = (lat == 1) ? pv1 : (lat == 2) ? pv2 : pv3;
  assign rsp_data  = (lat == 1) ? pd1 : (lat == 2) ? pd2 : pd3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1; pcsel = 1'b0; pc_branch = '0;
    req_ready = 1'b1; insn_ready = 1'b1; lat = l;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; pcsel = 1'b0; pc_branch = '0; req_ready = 1'b1; insn_ready = 1'b1;

    // Reset state and streaming start-up
    do_reset(1);
    chk1("rst_insn_valid", insn_valid, 1'b0);
    chk ("rst_insn", insn, 32'h0);
    chk ("rst_pc", pc, BASE);
    chk1("rst_req_valid", req_valid, 1'b1);
    chk ("rst_req_addr", req_addr, BASE);
    tick();
    chk ("c1_req_addr", req_addr, BASE + 32'd4);
    chk1("c1_insn_valid", insn_valid, 1'b0);
    tick();
    chk1("c2_insn_valid", insn_valid, 1'b1);
    chk ("c2_pc", pc, BASE);
    chk ("c2_insn", insn, BASE ^ KEY);
    tick();
    chk ("c3_pc", pc, BASE + 32'd4);
    chk ("c3_insn", insn, (BASE + 32'd4) ^ KEY);
    tick();
    chk ("c4_pc", pc, BASE + 32'd8);

    // Decode stall fills the queue up to the credit limit
    insn_ready = 1'b0;
    tick();
    chk1("stall_c5_req_valid", req_valid, 1'b1);
    chk ("stall_c5_req_addr", req_addr, BASE + 32'd20);
    tick();
    chk1("stall_c6_req_valid", req_valid, 1'b0);
    tick();
    chk1("stall_c7_req_valid", req_valid, 1'b0);
    chk ("stall_c7_req_addr", req_addr, BASE + 32'd24);
    chk ("stall_c7_pc", pc, BASE + 32'd8);
    chk ("stall_c7_insn", insn, (BASE + 32'd8) ^ KEY);
    tick();
    tick();
    chk1("stall_c9_req_valid", req_valid, 1'b0);
    chk1("stall_c9_insn_valid", insn_valid, 1'b1);
    insn_ready = 1'b1;
    tick();
    chk ("drain_c10_pc", pc, BASE + 32'd12);
    chk1("drain_c10_req_valid", req_valid, 1'b1);
    chk ("drain_c10_req_addr", req_addr, BASE + 32'd24);
    tick();
    chk ("drain_c11_pc", pc, BASE + 32'd16);
    tick();
    chk ("drain_c12_pc", pc, BASE + 32'd20);
    tick();
    chk ("drain_c13_pc", pc, BASE + 32'd24);
    chk ("drain_c13_insn", insn, (BASE + 32'd24) ^ KEY);

    // Redirect coinciding with a response and a decode pop; unaligned target
    do_reset(1);
    tick(); tick(); tick();
    pcsel = 1'b1; pc_branch = BASE + 32'h43;
    #1;
    chk1("rdir_same_insn_valid", insn_valid, 1'b0);
    chk1("rdir_same_req_valid", req_valid, 1'b0);
    tick();
    pcsel = 1'b0;
    #1;
    chk1("rdir_same_flushed", insn_valid, 1'b0);
    chk1("rdir_same_req_valid_next", req_valid, 1'b1);
    chk ("rdir_same_req_addr", req_addr, BASE + 32'h40);
    chk ("rdir_same_pc", pc, BASE + 32'h40);
    tick();
    chk1("rdir_same_c5_valid", insn_valid, 1'b0);
    tick();
    chk1("rdir_same_c6_valid", insn_valid, 1'b1);
    chk ("rdir_same_c6_pc", pc, BASE + 32'h40);
    chk ("rdir_same_c6_insn", insn, (BASE + 32'h40) ^ KEY);

    // Redirect with two requests in flight (3-cycle memory)
    do_reset(3);
    tick(); tick();
    pcsel = 1'b1; pc_branch = BASE + 32'h40;
    #1;
    chk1("drop2_req_valid", req_valid, 1'b0);
    tick();
    pcsel = 1'b0;
    #1;
    chk ("drop2_req_addr", req_addr, BASE + 32'h40);
    chk1("drop2_c3_valid", insn_valid, 1'b0);
    tick();
    chk1("drop2_c4_valid", insn_valid, 1'b0);
    tick(); tick();
    chk1("drop2_c6_valid", insn_valid, 1'b0);
    tick();
    chk1("drop2_c7_valid", insn_valid, 1'b1);
    chk ("drop2_c7_pc", pc, BASE + 32'h40);
    chk ("drop2_c7_insn", insn, (BASE + 32'h40) ^ KEY);

    // Two redirects on consecutive cycles: only the second target survives
    do_reset(3);
    tick(); tick();
    pcsel = 1'b1; pc_branch = 32'h0200_0000;
    tick();
    pc_branch = 32'h0300_0004;
    #1;
    chk1("b2b_req_valid", req_valid, 1'b0);
    tick();
    pcsel = 1'b0;
    #1;
    chk ("b2b_req_addr", req_addr, 32'h0300_0004);
    chk ("b2b_pc", pc, 32'h0300_0004);
    tick(); tick(); tick();
    chk1("b2b_c7_valid", insn_valid, 1'b0);
    tick();
    chk1("b2b_c8_valid", insn_valid, 1'b1);
    chk ("b2b_c8_pc", pc, 32'h0300_0004);
    chk ("b2b_c8_insn", insn, 32'h0300_0004 ^ KEY);

    // Address wrap at the top of the address space
    do_reset(1);
    tick();
    pcsel = 1'b1; pc_branch = 32'hFFFF_FFFC;
    tick();
    pcsel = 1'b0;
    #1;
    chk ("wrap_addr_top", req_addr, 32'hFFFF_FFFC);
    tick();
    chk ("wrap_addr_zero", req_addr, 32'h0000_0000);
    tick();
    chk ("wrap_pc_top", pc, 32'hFFFF_FFFC);
    tick();
    chk ("wrap_pc_zero", pc, 32'h0000_0000);
    chk ("wrap_insn_zero", insn, KEY);

    // Reset in the middle of a stalled, populated queue
    insn_ready = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk1("midrst_pre_valid", insn_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk1("midrst_insn_valid", insn_valid, 1'b0);
    chk1("midrst_req_valid", req_valid, 1'b1);
    chk ("midrst_req_addr", req_addr, BASE);
    chk ("midrst_pc", pc, BASE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
